mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage consumer of the EX/MEM pipeline outputs. Turns MemRead/MemWrite requests into transactions on a req/ack data-memory bus and stalls the front of the pipeline while a transaction is outstanding. Presents the registered MEM/WB stage values to write-back, substituting bubbles while stalled. Non-memory instructions pass through with one cycle of latency, exactly like a pipeline register.

## Interface
- TIMEOUT, 255: cycles in BUSY without mem_ack before abort; 0 disables the timeout.
- clk  input  1  pipeline clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset.
- RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in, ret_in  input  1 each  EX/MEM control outputs.
- DestReg_in  input  5  destination register.
- EX_in  input  32  ALU result; this is the memory address for memory ops.
- MemWrite_data_in  input  32  store data.
- mem_req  output  1  bus request, registered.
- mem_we  output  1  1 = write, 0 = read.
- mem_sel  output  1  region select, equal to latched MemSrc (0 data, 1 stack).
- mem_addr  output  32  latched EX_in.
- mem_wdata  output  32  latched MemWrite_data_in.
- mem_ack  input  1  transaction complete; read data valid in the same cycle.
- mem_rdata  input  32  read data.
- stall  output  1  combinational; upstream (PC, IF/ID, ID/EX, EX/MEM) holds while 1.
- RegWrite_out, MemToReg_out, ret_out  output  1 each  MEM/WB control.
- DestReg_out  output  5.
- EX_out  output  32  ALU result forwarded.
- Mem_data_out  output  32  load data; 0 for non-loads.
- mem_err  output  1  one-cycle pulse on timeout abort.

## Operation
- A memory op is `MemRead_in | MemWrite_in`. If both are set, the op is a write; no error is raised.
- FSM states: IDLE and BUSY.
- IDLE, no memory op:
  - Each posedge copies all *_in fields to the *_out fields.
  - Mem_data_out <= 0.
  - stall = 0.
- IDLE, memory op (accept cycle):
  - stall = 1.
  - At the posedge, latch all inputs into the internal holding register.
  - Drive mem_addr, mem_wdata, mem_we, mem_sel from the latched values and set mem_req <= 1.
  - Load the timeout counter with 0.
  - Go to BUSY.
  - MEM/WB outputs receive a bubble: all *_out = 0.
- BUSY:
  - mem_req stays 1 and the bus fields are stable.
  - `stall = ~mem_ack`.
  - If mem_ack = 1 at a posedge:
    - MEM/WB outputs <= latched controls, DestReg, and EX.
    - Mem_data_out <= mem_rdata if the op was a read, else 0.
    - mem_req <= 0, then go to IDLE.
  - Else, if TIMEOUT ≠ 0 and counter == TIMEOUT-1:
    - Abort: bubble on MEM/WB, mem_err <= 1 for one cycle, mem_req <= 0, go to IDLE.
    - stall is 0 in that cycle, so the faulting instruction is dropped.
  - Else: counter increments and a bubble goes to MEM/WB.
- mem_ack while in IDLE is ignored.
- The counter width is the minimum needed to hold TIMEOUT-1. It saturates and never wraps.
- The holding register is used for the whole transaction, so changes on the inputs during BUSY have no effect.

## Timing
- Reset (rst_n = 0 at a posedge):
  - State IDLE, counter 0.
  - mem_req, mem_we, mem_sel, mem_addr, mem_wdata, every *_out, and mem_err are all 0.
- stall while rst_n = 0 is 0.
- Reset during BUSY aborts the transaction. mem_req is 0 from the next cycle, and a later mem_ack is ignored.
- Non-memory op: 1-cycle latency, no stall.
- Zero-wait memory (mem_ack in the first BUSY cycle):
  - stall is 1 for exactly one cycle (the accept cycle).
  - MEM/WB is valid 2 cycles after the op first appears.
- N wait cycles: stall = N+1 cycles and latency = N+2.
- mem_req deasserts on the posedge after ack. A back-to-back memory op is accepted in the following IDLE cycle.
- There is therefore at least 1 idle bus cycle between requests.
- mem_err: high for exactly the one cycle after the abort edge.

## Test plan
- ALU op passthrough: RegWrite_in=1, DestReg_in=5, EX_in=0x1234 with no memory op -> next cycle RegWrite_out=1, DestReg_out=5, EX_out=0x1234, Mem_data_out=0; stall never 1.
- Zero-wait load: MemRead_in=1, MemToReg_in=1, EX_in=0x40, mem_ack tied high with mem_rdata=0xDEADBEEF -> stall high 1 cycle; mem_req=1, mem_we=0, mem_addr=0x40 for 1 cycle; 2 cycles after issue RegWrite_out=1, Mem_data_out=0xDEADBEEF.
- Waited store: MemWrite_in=1, EX_in=0x80, MemWrite_data_in=0xA5A5A5A5, ack after 3 wait cycles -> stall 4 cycles; mem_we=1, mem_wdata stable throughout even if the inputs change; then a bubble-free write-back with Mem_data_out=0.
- Timeout: TIMEOUT=4, load, mem_ack never asserted -> mem_req high 4 cycles, then mem_err pulses for 1 cycle, stall drops, RegWrite_out stays 0, and the next instruction proceeds.
- Back-to-back: two loads in consecutive EX/MEM slots with zero-wait ack -> two distinct transactions with one gap cycle between mem_req pulses; both results reach MEM/WB in order.
- Reset mid-BUSY: rst_n=0 for 1 cycle during a waited read -> all outputs 0 the next cycle; a late mem_ack produces no write-back.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - req/ack data-memory bus between the memory stage and data memory
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: issues req/ack memory transactions, stalls upstream, feeds MEM/WB
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWrite_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic        MemToReg_in,
  input  logic        MemSrc_in,
  input  logic        ret_in,
  input  logic [4:0]  DestReg_in,
  input  logic [31:0] EX_in,
  input  logic [31:0] MemWrite_data_in,
  mem_access_unit_if.master bus,
  output logic        stall,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic        ret_out,
  output logic [4:0]  DestReg_out,
  output logic [31:0] EX_out,
  output logic [31:0] Mem_data_out,
  output logic        mem_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        h_regwrite_q, h_regwrite_d;
  logic        h_memwrite_q, h_memwrite_d;
  logic        h_memread_q,  h_memread_d;
  logic        h_memtoreg_q, h_memtoreg_d;
  logic        h_memsrc_q,   h_memsrc_d;
  logic        h_ret_q,      h_ret_d;
  logic [4:0]  h_dest_q,     h_dest_d;
  logic [31:0] h_ex_q,       h_ex_d;
  logic [31:0] h_wdata_q,    h_wdata_d;

  logic        mem_req_q, mem_req_d;
  logic        regwrite_out_q, regwrite_out_d;
  logic        memtoreg_out_q, memtoreg_out_d;
  logic        ret_out_q,      ret_out_d;
  logic [4:0]  dest_out_q,     dest_out_d;
  logic [31:0] ex_out_q,       ex_out_d;
  logic [31:0] mdata_out_q,    mdata_out_d;
  logic        mem_err_q,      mem_err_d;
  logic        stall_c;

  logic mem_op;
  logic timeout_hit;
  logic hold_is_read;

  // Write wins when both MemRead and MemWrite are set.
  assign mem_op       = MemRead_in | MemWrite_in;
  assign hold_is_read = h_memread_q & ~h_memwrite_q;
  assign timeout_hit  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      h_regwrite_q   <= 1'b0;
      h_memwrite_q   <= 1'b0;
      h_memread_q    <= 1'b0;
      h_memtoreg_q   <= 1'b0;
      h_memsrc_q     <= 1'b0;
      h_ret_q        <= 1'b0;
      h_dest_q       <= '0;
      h_ex_q         <= '0;
      h_wdata_q      <= '0;
      mem_req_q      <= 1'b0;
      regwrite_out_q <= 1'b0;
      memtoreg_out_q <= 1'b0;
      ret_out_q      <= 1'b0;
      dest_out_q     <= '0;
      ex_out_q       <= '0;
      mdata_out_q    <= '0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      h_regwrite_q   <= h_regwrite_d;
      h_memwrite_q   <= h_memwrite_d;
      h_memread_q    <= h_memread_d;
      h_memtoreg_q   <= h_memtoreg_d;
      h_memsrc_q     <= h_memsrc_d;
      h_ret_q        <= h_ret_d;
      h_dest_q       <= h_dest_d;
      h_ex_q         <= h_ex_d;
      h_wdata_q      <= h_wdata_d;
      mem_req_q      <= mem_req_d;
      regwrite_out_q <= regwrite_out_d;
      memtoreg_out_q <= memtoreg_out_d;
      ret_out_q      <= ret_out_d;
      dest_out_q     <= dest_out_d;
      ex_out_q       <= ex_out_d;
      mdata_out_q    <= mdata_out_d;
      mem_err_q      <= mem_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op) state_d = BUSY;
      BUSY:    if (bus.mem_ack || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MEM/WB fields default to a bubble; only passthrough or a completed ack fill them.
  always_comb begin
    stall_c        = 1'b0;
    cnt_d          = cnt_q;
    h_regwrite_d   = h_regwrite_q;
    h_memwrite_d   = h_memwrite_q;
    h_memread_d    = h_memread_q;
    h_memtoreg_d   = h_memtoreg_q;
    h_memsrc_d     = h_memsrc_q;
    h_ret_d        = h_ret_q;
    h_dest_d       = h_dest_q;
    h_ex_d         = h_ex_q;
    h_wdata_d      = h_wdata_q;
    mem_req_d      = mem_req_q;
    regwrite_out_d = 1'b0;
    memtoreg_out_d = 1'b0;
    ret_out_d      = 1'b0;
    dest_out_d     = '0;
    ex_out_d       = '0;
    mdata_out_d    = '0;
    mem_err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall_c      = 1'b1;
          h_regwrite_d = RegWrite_in;
          h_memwrite_d = MemWrite_in;
          h_memread_d  = MemRead_in;
          h_memtoreg_d = MemToReg_in;
          h_memsrc_d   = MemSrc_in;
          h_ret_d      = ret_in;
          h_dest_d     = DestReg_in;
          h_ex_d       = EX_in;
          h_wdata_d    = MemWrite_data_in;
          mem_req_d    = 1'b1;
          cnt_d        = '0;
        end else begin
          regwrite_out_d = RegWrite_in;
          memtoreg_out_d = MemToReg_in;
          ret_out_d      = ret_in;
          dest_out_d     = DestReg_in;
          ex_out_d       = EX_in;
        end
      end
      BUSY: begin
        // On abort stall drops so the pipeline moves on without the faulting op.
        stall_c = ~bus.mem_ack & ~timeout_hit;
        if (bus.mem_ack) begin
          regwrite_out_d = h_regwrite_q;
          memtoreg_out_d = h_memtoreg_q;
          ret_out_d      = h_ret_q;
          dest_out_d     = h_dest_q;
          ex_out_d       = h_ex_q;
          mdata_out_d    = hold_is_read ? bus.mem_rdata : 32'd0;
          mem_req_d      = 1'b0;
        end else if (timeout_hit) begin
          mem_err_d = 1'b1;
          mem_req_d = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign stall         = rst_n & stall_c;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = h_memwrite_q;
  assign bus.mem_sel   = h_memsrc_q;
  assign bus.mem_addr  = h_ex_q;
  assign bus.mem_wdata = h_wdata_q;
  assign RegWrite_out  = regwrite_out_q;
  assign MemToReg_out  = memtoreg_out_q;
  assign ret_out       = ret_out_q;
  assign DestReg_out   = dest_out_q;
  assign EX_out        = ex_out_q;
  assign Mem_data_out  = mdata_out_q;
  assign mem_err       = mem_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in, ret_in;
  logic [4:0]  DestReg_in;
  logic [31:0] EX_in, MemWrite_data_in;
  logic        stall, RegWrite_out, MemToReg_out, ret_out, mem_err;
  logic [4:0]  DestReg_out;
  logic [31:0] EX_out, Mem_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .RegWrite_in      (RegWrite_in),
    .MemWrite_in      (MemWrite_in),
    .MemRead_in       (MemRead_in),
    .MemToReg_in      (MemToReg_in),
    .MemSrc_in        (MemSrc_in),
    .ret_in           (ret_in),
    .DestReg_in       (DestReg_in),
    .EX_in            (EX_in),
    .MemWrite_data_in (MemWrite_data_in),
    .bus              (bus_if),
    .stall            (stall),
    .RegWrite_out     (RegWrite_out),
    .MemToReg_out     (MemToReg_out),
    .ret_out          (ret_out),
    .DestReg_out      (DestReg_out),
    .EX_out           (EX_out),
    .Mem_data_out     (Mem_data_out),
    .mem_err          (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_in();
    RegWrite_in = 0; MemWrite_in = 0; MemRead_in = 0; MemToReg_in = 0;
    MemSrc_in = 0; ret_in = 0; DestReg_in = 0; EX_in = 0; MemWrite_data_in = 0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [31:0] addr);
    clr_in();
    RegWrite_in = 1; MemRead_in = 1; MemToReg_in = 1; DestReg_in = rd; EX_in = addr;
  endtask

  initial begin
    clr_in();
    bus_if.mem_ack = 0;
    bus_if.mem_rdata = 0;
    rst_n = 0;
    MemRead_in = 1;
    tick();
    settle();
    check("stall_in_reset", stall, 0);
    tick();
    clr_in();
    settle();
    check("rst_mem_req", bus_if.mem_req, 0);
    check("rst_mem_addr", bus_if.mem_addr, 0);
    check("rst_regwrite_out", RegWrite_out, 0);
    check("rst_mem_err", mem_err, 0);
    rst_n = 1;
    tick();

    // ALU passthrough
    RegWrite_in = 1; DestReg_in = 5; EX_in = 32'h1234;
    settle();
    check("alu_stall", stall, 0);
    tick();
    clr_in();
    settle();
    check("alu_regwrite", RegWrite_out, 1);
    check("alu_dest", DestReg_out, 5);
    check("alu_ex", EX_out, 32'h1234);
    check("alu_mdata", Mem_data_out, 0);
    check("alu_stall2", stall, 0);
    tick();

    // Zero-wait load
    load(7, 32'h40);
    bus_if.mem_ack = 1; bus_if.mem_rdata = 32'hDEADBEEF;
    settle();
    check("zw_accept_stall", stall, 1);
    check("zw_accept_req", bus_if.mem_req, 0);
    tick();
    settle();
    check("zw_busy_req", bus_if.mem_req, 1);
    check("zw_busy_we", bus_if.mem_we, 0);
    check("zw_busy_addr", bus_if.mem_addr, 32'h40);
    check("zw_busy_stall", stall, 0);
    check("zw_busy_bubble", RegWrite_out, 0);
    tick();
    clr_in();
    bus_if.mem_ack = 0;
    settle();
    check("zw_req_drop", bus_if.mem_req, 0);
    check("zw_regwrite", RegWrite_out, 1);
    check("zw_memtoreg", MemToReg_out, 1);
    check("zw_dest", DestReg_out, 7);
    check("zw_data", Mem_data_out, 32'hDEADBEEF);
    tick();

    // Waited store, 3 wait cycles, inputs disturbed during BUSY
    clr_in();
    MemWrite_in = 1; EX_in = 32'h80; MemWrite_data_in = 32'hA5A5A5A5; MemSrc_in = 1;
    settle();
    check("st_accept_stall", stall, 1);
    tick();
    EX_in = 32'hFFFF0000; MemWrite_data_in = 32'h12345678; MemSrc_in = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("st_wait_stall", stall, 1);
      check("st_wait_req", bus_if.mem_req, 1);
      check("st_wait_we", bus_if.mem_we, 1);
      check("st_wait_sel", bus_if.mem_sel, 1);
      check("st_wait_addr", bus_if.mem_addr, 32'h80);
      check("st_wait_wdata", bus_if.mem_wdata, 32'hA5A5A5A5);
      tick();
    end
    bus_if.mem_ack = 1; bus_if.mem_rdata = 32'h55;
    settle();
    check("st_ack_stall", stall, 0);
    tick();
    clr_in();
    bus_if.mem_ack = 0;
    settle();
    check("st_req_drop", bus_if.mem_req, 0);
    check("st_mdata", Mem_data_out, 0);
    check("st_ex", EX_out, 32'h80);
    tick();

    // Timeout abort with TIMEOUT=4
    load(3, 32'h100);
    settle();
    check("to_accept_stall", stall, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("to_wait_req", bus_if.mem_req, 1);
      check("to_wait_stall", stall, 1);
      check("to_wait_err", mem_err, 0);
      tick();
    end
    settle();
    check("to_last_req", bus_if.mem_req, 1);
    check("to_abort_stall", stall, 0);
    tick();
    clr_in();
    RegWrite_in = 1; DestReg_in = 9; EX_in = 32'h99;
    settle();
    check("to_err_pulse", mem_err, 1);
    check("to_req_drop", bus_if.mem_req, 0);
    check("to_bubble", RegWrite_out, 0);
    check("to_next_stall", stall, 0);
    tick();
    clr_in();
    settle();
    check("to_err_clear", mem_err, 0);
    check("to_next_regwrite", RegWrite_out, 1);
    check("to_next_dest", DestReg_out, 9);
    tick();

    // Back-to-back zero-wait loads
    load(1, 32'h10);
    bus_if.mem_ack = 1; bus_if.mem_rdata = 32'h11111111;
    settle();
    check("bb_a_accept_stall", stall, 1);
    tick();
    settle();
    check("bb_a_req", bus_if.mem_req, 1);
    check("bb_a_addr", bus_if.mem_addr, 32'h10);
    tick();
    load(2, 32'h20);
    bus_if.mem_rdata = 32'h22222222;
    settle();
    check("bb_gap_req", bus_if.mem_req, 0);
    check("bb_b_accept_stall", stall, 1);
    check("bb_a_dest", DestReg_out, 1);
    check("bb_a_data", Mem_data_out, 32'h11111111);
    tick();
    settle();
    check("bb_b_req", bus_if.mem_req, 1);
    check("bb_b_addr", bus_if.mem_addr, 32'h20);
    check("bb_b_bubble", RegWrite_out, 0);
    tick();
    clr_in();
    bus_if.mem_ack = 0;
    settle();
    check("bb_b_dest", DestReg_out, 2);
    check("bb_b_data", Mem_data_out, 32'h22222222);
    check("bb_b_req_drop", bus_if.mem_req, 0);
    tick();

    // Reset during a waited read
    load(4, 32'h200);
    tick();
    settle();
    check("rb_busy_req", bus_if.mem_req, 1);
    rst_n = 0;
    settle();
    check("rb_stall_in_reset", stall, 0);
    tick();
    rst_n = 1;
    clr_in();
    bus_if.mem_ack = 1; bus_if.mem_rdata = 32'hBAD;
    settle();
    check("rb_req", bus_if.mem_req, 0);
    check("rb_addr", bus_if.mem_addr, 0);
    check("rb_regwrite", RegWrite_out, 0);
    check("rb_stall", stall, 0);
    tick();
    bus_if.mem_ack = 0;
    settle();
    check("rb_late_ack_regwrite", RegWrite_out, 0);
    check("rb_late_ack_data", Mem_data_out, 0);
    check("rb_late_ack_dest", DestReg_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
